// File: rtl/minmax_scan.sv
// minmax_scan: streaming signed min/max reduction with index tracking.
//
// Takes a block of len signed words over a valid/ready handshake. It keeps
// the running minimum and maximum and the 0-based index of each. A one-cycle
// done pulse marks the results as final. The results then hold until the
// next accepted start.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     begin a scan (sampled only in IDLE)
//   len       number of words to scan, sampled with start
//   in_valid  producer has a word on in_data
//   in_ready  block accepts a word this cycle
//   in_data   signed input word
//   busy      high in SCAN and DONE
//   done      one-cycle pulse when results are final
//   min_out   running/final signed minimum
//   max_out   running/final signed maximum
//   min_idx   index of min_out within the scan
//   max_idx   index of max_out within the scan
module minmax_scan #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic [CNT_W-1:0] min_idx,
  output logic [CNT_W-1:0] max_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed a < b built from the sign bits and a plain WIDTH-bit subtraction.
  // When the signs differ, the subtraction could overflow. In that case the
  // sign of a alone decides the result. When the signs match, the MSB of the
  // difference is correct.
  function automatic logic slt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] diff;
    diff = a - b;
    if (a[WIDTH-1] != b[WIDTH-1]) begin
      slt = a[WIDTH-1];
    end else begin
      slt = diff[WIDTH-1];
    end
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [CNT_W-1:0] len_r, len_s;
  logic [WIDTH-1:0] min_r, min_s;
  logic [WIDTH-1:0] max_r, max_s;
  logic [CNT_W-1:0] min_idx_r, min_idx_s;
  logic [CNT_W-1:0] max_idx_r, max_idx_s;
  logic             in_ready_r, busy_r, done_r;
  logic             xfer_s;

  // Transfers can only happen in SCAN, where in_ready is guaranteed high.
  assign xfer_s = (state_r == SCAN) && in_valid;

  // Next-state and next-datapath logic.
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    len_s     = len_r;
    min_s     = min_r;
    max_s     = max_r;
    min_idx_s = min_idx_r;
    max_idx_s = max_idx_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          count_s   = {CNT_W{1'b0}};
          min_s     = {WIDTH{1'b0}};
          max_s     = {WIDTH{1'b0}};
          min_idx_s = {CNT_W{1'b0}};
          max_idx_s = {CNT_W{1'b0}};
          len_s     = len;
          if (len != {CNT_W{1'b0}}) begin
            state_s = SCAN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (xfer_s) begin
          if (count_r == {CNT_W{1'b0}}) begin
            min_s     = in_data;
            max_s     = in_data;
            min_idx_s = {CNT_W{1'b0}};
            max_idx_s = {CNT_W{1'b0}};
          end else begin
            // Strict compares: a tie keeps the earlier index.
            if (slt(in_data, min_r)) begin
              min_s     = in_data;
              min_idx_s = count_r;
            end else begin
              min_s     = min_r;
            end
            if (slt(max_r, in_data)) begin
              max_s     = in_data;
              max_idx_s = count_r;
            end else begin
              max_s     = max_r;
            end
          end
          count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (count_r == (len_r - {{(CNT_W-1){1'b0}}, 1'b1})) begin
            state_s = DONE;
          end else begin
            state_s = SCAN;
          end
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      count_r    <= {CNT_W{1'b0}};
      len_r      <= {CNT_W{1'b0}};
      min_r      <= {WIDTH{1'b0}};
      max_r      <= {WIDTH{1'b0}};
      min_idx_r  <= {CNT_W{1'b0}};
      max_idx_r  <= {CNT_W{1'b0}};
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      len_r      <= len_s;
      min_r      <= min_s;
      max_r      <= max_s;
      min_idx_r  <= min_idx_s;
      max_idx_r  <= max_idx_s;
      in_ready_r <= (state_s == SCAN);
      busy_r     <= (state_s != IDLE);
      done_r     <= (state_s == DONE);
    end
  end

  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign min_out  = min_r;
  assign max_out  = max_r;
  assign min_idx  = min_idx_r;
  assign max_idx  = max_idx_r;

endmodule

// File: tb/tb_minmax_scan.sv
// Testbench for minmax_scan: table-driven scans plus hand-written sequences
// for reset abort, empty scan and ignored/back-to-back start.
module tb_minmax_scan;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        busy;
  logic        done;
  logic [31:0] min_out;
  logic [31:0] max_out;
  logic [15:0] min_idx;
  logic [15:0] max_idx;

  int errors = 0;
  int checks = 0;

  minmax_scan #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done), .min_out(min_out), .max_out(max_out),
    .min_idx(min_idx), .max_idx(max_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      len;
    logic [3:0]       nbeats;
    logic [7:0][31:0] data;
    logic [7:0]       vld;
    logic [31:0]      emin;
    logic [31:0]      emax;
    logic [15:0]      emin_idx;
    logic [15:0]      emax_idx;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_results(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                             input logic [15:0] mni, input logic [15:0] mxi);
    chk({tag, " min_out"}, min_out, mn);
    chk({tag, " max_out"}, max_out, mx);
    chk({tag, " min_idx"}, {16'd0, min_idx}, {16'd0, mni});
    chk({tag, " max_idx"}, {16'd0, max_idx}, {16'd0, max_idx_dummy(mxi)});
  endtask

  function automatic logic [15:0] max_idx_dummy(input logic [15:0] v);
    return v;
  endfunction

  task automatic do_start(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
    len   = 16'd0;
  endtask

  task automatic set_vec(input int k, input logic [15:0] l, input logic [3:0] nb,
                         input logic [31:0] mn, input logic [31:0] mx,
                         input logic [15:0] mni, input logic [15:0] mxi);
    vecs[k] = '0;
    vecs[k].len = l;
    vecs[k].nbeats = nb;
    vecs[k].emin = mn;
    vecs[k].emax = mx;
    vecs[k].emin_idx = mni;
    vecs[k].emax_idx = mxi;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 16'd0; in_valid = 1'b0; in_data = 32'd0;

    // Mixed signs with a tie on the maximum at index 4.
    set_vec(0, 16'd5, 4'd5, 32'h80000000, 32'd7, 16'd3, 16'd2);
    vecs[0].data[0] = 32'd3;         vecs[0].data[1] = 32'hFFFFFFFE;
    vecs[0].data[2] = 32'd7;         vecs[0].data[3] = 32'h80000000;
    vecs[0].data[4] = 32'd7;         vecs[0].vld = 8'b0001_1111;
    // Sign-boundary compare: a naive MSB-of-difference compare overflows here.
    set_vec(1, 16'd2, 4'd2, 32'h80000000, 32'h7FFFFFFF, 16'd1, 16'd0);
    vecs[1].data[0] = 32'h7FFFFFFF;  vecs[1].data[1] = 32'h80000000;
    vecs[1].vld = 8'b0000_0011;
    // Backpressure: valid 1,0,0,1,0,1 gives three transfers.
    set_vec(2, 16'd3, 4'd6, 32'd1, 32'd9, 16'd1, 16'd2);
    vecs[2].data[0] = 32'd5;         vecs[2].data[1] = 32'hDEADBEEF;
    vecs[2].data[2] = 32'h12345678;  vecs[2].data[3] = 32'd1;
    vecs[2].data[4] = 32'h80000000;  vecs[2].data[5] = 32'd9;
    vecs[2].vld = 8'b0010_1001;
    // All negative with a tie on the first minimum.
    set_vec(3, 16'd4, 4'd4, 32'hFFFFFFF7, 32'hFFFFFFFF, 16'd3, 16'd2);
    vecs[3].data[0] = 32'hFFFFFFFB;  vecs[3].data[1] = 32'hFFFFFFFB;
    vecs[3].data[2] = 32'hFFFFFFFF;  vecs[3].data[3] = 32'hFFFFFFF7;
    vecs[3].vld = 8'b0000_1111;
    // Single word.
    set_vec(4, 16'd1, 4'd1, 32'd42, 32'd42, 16'd0, 16'd0);
    vecs[4].data[0] = 32'd42;        vecs[4].vld = 8'b0000_0001;
    // Positive words, minimum found last.
    set_vec(5, 16'd3, 4'd3, 32'd5, 32'd20, 16'd2, 16'd1);
    vecs[5].data[0] = 32'd10;        vecs[5].data[1] = 32'd20;
    vecs[5].data[2] = 32'd5;         vecs[5].vld = 8'b0000_0111;

    #12;
    chk1("reset in_ready", in_ready, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk_results("reset", 32'd0, 32'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    step();

    // Table-driven scans.
    for (int k = 0; k < 6; k++) begin
      do_start(vecs[k].len);
      chk1($sformatf("v%0d busy after start", k), busy, 1'b1);
      chk_results($sformatf("v%0d cleared", k), 32'd0, 32'd0, 16'd0, 16'd0);
      for (int b = 0; b < int'(vecs[k].nbeats); b++) begin
        chk1($sformatf("v%0d b%0d in_ready", k, b), in_ready, 1'b1);
        chk1($sformatf("v%0d b%0d no early done", k, b), done, 1'b0);
        in_valid = vecs[k].vld[b];
        in_data  = vecs[k].data[b];
        step();
      end
      in_valid = 1'b0;
      in_data  = 32'd0;
      chk1($sformatf("v%0d done", k), done, 1'b1);
      chk1($sformatf("v%0d busy in done", k), busy, 1'b1);
      chk1($sformatf("v%0d in_ready in done", k), in_ready, 1'b0);
      chk_results($sformatf("v%0d final", k), vecs[k].emin, vecs[k].emax,
                  vecs[k].emin_idx, vecs[k].emax_idx);
      step();
      chk1($sformatf("v%0d done one cycle", k), done, 1'b0);
      chk1($sformatf("v%0d idle busy", k), busy, 1'b0);
      chk_results($sformatf("v%0d hold", k), vecs[k].emin, vecs[k].emax,
                  vecs[k].emin_idx, vecs[k].emax_idx);
    end

    // Reset mid-scan: abort with no done pulse.
    do_start(16'd4);
    in_valid = 1'b1; in_data = 32'd11; step();
    in_data = 32'd22; step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("rst mid in_ready", in_ready, 1'b0);
    chk1("rst mid busy", busy, 1'b0);
    chk1("rst mid done", done, 1'b0);
    chk_results("rst mid", 32'd0, 32'd0, 16'd0, 16'd0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'd33;
    for (int c = 0; c < 4; c++) begin
      step();
      chk1($sformatf("post rst c%0d done", c), done, 1'b0);
      chk1($sformatf("post rst c%0d in_ready", c), in_ready, 1'b0);
    end
    in_valid = 1'b0;

    // Preload results, then an empty scan must clear them.
    do_start(16'd1);
    in_valid = 1'b1; in_data = 32'd99; step(); in_valid = 1'b0;
    step();
    chk("preload min", min_out, 32'd99);
    in_valid = 1'b1; in_data = 32'd5;
    do_start(16'd0);
    chk1("len0 done", done, 1'b1);
    chk1("len0 busy", busy, 1'b1);
    chk1("len0 in_ready", in_ready, 1'b0);
    chk_results("len0", 32'd0, 32'd0, 16'd0, 16'd0);
    step();
    chk1("len0 done once", done, 1'b0);
    chk1("len0 in_ready after", in_ready, 1'b0);
    chk_results("len0 hold", 32'd0, 32'd0, 16'd0, 16'd0);
    in_valid = 1'b0;

    // start held during SCAN and the DONE cycle is ignored.
    do_start(16'd3);
    start = 1'b1; len = 16'd6;
    in_valid = 1'b1; in_data = 32'd4; step();
    in_data = 32'd2; step();
    in_data = 32'd8; step();
    in_valid = 1'b0;
    chk1("ign done", done, 1'b1);
    chk_results("ign final", 32'd2, 32'd8, 16'd1, 16'd2);
    len = 16'd0;
    step();
    chk1("ign no second done", done, 1'b0);
    chk1("ign idle busy", busy, 1'b0);
    chk_results("ign hold", 32'd2, 32'd8, 16'd1, 16'd2);
    // Back-to-back start in the following IDLE cycle.
    len = 16'd1;
    step();
    start = 1'b0; len = 16'd0;
    chk1("b2b busy", busy, 1'b1);
    chk1("b2b in_ready", in_ready, 1'b1);
    chk_results("b2b cleared", 32'd0, 32'd0, 16'd0, 16'd0);
    in_valid = 1'b1; in_data = 32'd77; step(); in_valid = 1'b0;
    chk1("b2b done", done, 1'b1);
    chk_results("b2b final", 32'd77, 32'd77, 16'd0, 16'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/minmax_scan.md
Name: minmax_scan

Overview:
Sequential stage directly downstream of the ALU's 32-bit signed less-than unit. It consumes a stream of signed words and tracks the running minimum and maximum, plus the index of each, using signed less-than compares. Software-visible results are read after a one-cycle done pulse. It is used by the multi-cycle datapath for min/max reduction over a block of register or memory values.

Parameters:
WIDTH, 32, data word width (two's complement signed)
CNT_W, 16, width of length counter and index outputs

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a scan; sampled only in IDLE
len  input  CNT_W  number of words to scan; sampled with start
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block accepts a word this cycle
in_data  input  WIDTH  signed input word
busy  output  1  high in SCAN and DONE
done  output  1  one-cycle pulse when results are final
min_out  output  WIDTH  running or final signed minimum
max_out  output  WIDTH  running or final signed maximum
min_idx  output  CNT_W  index (0-based) of min_out within the scan
max_idx  output  CNT_W  index (0-based) of max_out within the scan

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, count=0. All outputs 0: in_ready, busy, done, min_out, max_out, min_idx, max_idx. Reset mid-scan aborts the scan with no done pulse.
- States: IDLE, SCAN, DONE. All registers update on the rising clk edge.
- IDLE: in_ready=0, busy=0. If start=1 and len!=0, latch len, clear count and all four result registers to 0, go to SCAN. If start=1 and len==0, clear the results and go to DONE (empty scan: outputs 0). If start=0, hold the results from the previous scan.
- SCAN: in_ready=1. A transfer occurs when in_valid and in_ready are both 1; in_valid low stalls with no state change.
  - First transfer (count==0): min_out=max_out=in_data, min_idx=max_idx=0.
  - Later transfers: if in_data <s min_out, load min_out=in_data and min_idx=count. If max_out <s in_data, load max_out=in_data and max_idx=count. Both may update on the same word only when count==0.
  - Ties do not update, so the earliest index wins.
  - count increments on each transfer. The transfer with count==len-1 moves to DONE. in_ready drops to 0 in the next cycle.
- Signed compare a <s b: if a[WIDTH-1]!=b[WIDTH-1], the result is a[WIDTH-1]. Otherwise the result is the MSB of (a-b). Compute the subtraction WIDTH bits wide with no overflow trap.
- DONE: done=1 for exactly one cycle, busy=1, in_ready=0. Results are stable. Next state is IDLE unconditionally.
- start outside IDLE is ignored, including in the DONE cycle.
- Latency: done is asserted in the cycle after the last accepted word. The minimum scan time is len+2 cycles from the start cycle, with in_valid held high.
- Results stay valid in IDLE until the next start is accepted.
- Counter width: len up to 2^CNT_W-1. No wrap is possible because the scan ends at len-1.

Test Plan:
- Reset mid-scan: start len=4, accept 2 words, pulse rst_n low -> all outputs 0, state IDLE, no done pulse.
- Mixed signs, len=5, data 3, -2, 7, 0x80000000, 7 -> done after the 5th transfer; min_out=0x80000000, min_idx=3; max_out=7, max_idx=2 (tie at index 4 ignored).
- Sign-boundary compare, len=2, data 0x7FFFFFFF, 0x80000000 -> max_out=0x7FFFFFFF idx 0; min_out=0x80000000 idx 1. Verifies there is no subtraction-overflow error.
- Backpressure, len=3, in_valid toggling 1,0,0,1,0,1 with data 5,x,x,1,x,9 -> only 3 transfers counted; min=1 idx1, max=9 idx2; done is one cycle.
- len=0 start -> DONE next cycle, done=1 once, all results 0, in_ready never 1.
- start asserted during SCAN and during the DONE cycle -> ignored; results and count unaffected; a back-to-back start in the following IDLE cycle is accepted.
